// File: rtl/branch_pkg.sv
// Shared definitions for the branch unit: opcode encodings, FSM states and the
// helper that identifies branch-class opcodes.
package branch_pkg;

   localparam logic [4:0] OP_BGT = 5'h0D;
   localparam logic [4:0] OP_BEQ = 5'h0E;
   localparam logic [4:0] OP_BGE = 5'h0F;
   localparam logic [4:0] OP_BLT = 5'h10;
   localparam logic [4:0] OP_BLE = 5'h11;
   localparam logic [4:0] OP_BRN = 5'h12;
   localparam logic [4:0] OP_BNE = 5'h13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RES  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Branch encodings are contiguous, so a range test covers the whole set.
   function automatic logic is_branch(input logic [4:0] op);
      return (op >= OP_BGT) && (op <= OP_BNE);
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational condition evaluator: signed/unsigned compare selected by opcode.
// Non-branch opcodes always evaluate not-taken.
module branch_cmp
   import branch_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_x1,
   input  logic [DATA_W-1:0] i_x2,
   input  logic              i_cmp_signed,
   input  logic [4:0]        i_opcode,
   output logic              o_cond,
   output logic              o_is_br
);

   logic w_eq;
   logic w_lt;

   assign w_eq    = (i_x1 == i_x2);
   assign w_lt    = i_cmp_signed ? ($signed(i_x1) < $signed(i_x2)) : (i_x1 < i_x2);
   assign o_is_br = is_branch(i_opcode);

   // NOTE: o_cond gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      o_cond = 1'b0;
      case (i_opcode)
         OP_BGT:  o_cond = !w_lt && !w_eq;
         OP_BEQ:  o_cond = w_eq;
         OP_BGE:  o_cond = !w_lt;
         OP_BLT:  o_cond = w_lt;
         OP_BLE:  o_cond = w_lt || w_eq;
         OP_BRN:  o_cond = 1'b1;
         OP_BNE:  o_cond = !w_eq;
         default: o_cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit_seq.sv
// Registered branch-resolution unit: accepts one op per handshake, pulses the
// resolution one cycle later, holds a redirect until acked, and keeps saturating stats.
module branch_unit_seq
   import branch_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 16,
   parameter int REL_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        opcode,
   input  logic              cmp_signed,
   input  logic              rel,
   input  logic [DATA_W-1:0] x1,
   input  logic [DATA_W-1:0] x2,
   input  logic [IMM_W-1:0]  imm,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              res_valid,
   output logic              res_taken,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_addr,
   input  logic              redirect_ack,
   input  logic              flush,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  br_count,
   output logic [CNT_W-1:0]  taken_count
);

   state_t            r_state;
   logic              r_cond;
   logic              r_is_br;
   logic [ADDR_W-1:0] r_target;
   logic              r_in_ready;
   logic              r_res_valid;
   logic              r_res_taken;
   logic              r_redirect_valid;
   logic [CNT_W-1:0]  r_br_count;
   logic [CNT_W-1:0]  r_taken_count;

   logic              w_cond;
   logic              w_is_br;
   logic              w_accept;
   logic              w_cnt_inc;
   logic [ADDR_W-1:0] w_imm_sext;
   logic [ADDR_W-1:0] w_imm_zext;
   logic [ADDR_W-1:0] w_target;

   branch_cmp #(.DATA_W(DATA_W)) u_cmp (
      .i_x1         (x1),
      .i_x2         (x2),
      .i_cmp_signed (cmp_signed),
      .i_opcode     (opcode),
      .o_cond       (w_cond),
      .o_is_br      (w_is_br)
   );

   generate
      if (IMM_W >= ADDR_W) begin : g_imm_trunc
         assign w_imm_sext = imm[ADDR_W-1:0];
         assign w_imm_zext = imm[ADDR_W-1:0];
      end else begin : g_imm_ext
         assign w_imm_sext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
         assign w_imm_zext = {{(ADDR_W-IMM_W){1'b0}}, imm};
      end
   endgenerate

   assign w_target  = (rel && (REL_EN != 0)) ? (pc_in + w_imm_sext) : w_imm_zext;
   assign w_accept  = (r_state == ST_IDLE) && in_valid && !flush;
   assign w_cnt_inc = (r_state == ST_RES) && r_is_br;

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_cond           <= 1'b0;
         r_is_br          <= 1'b0;
         r_target         <= '0;
         r_in_ready       <= 1'b1;
         r_res_valid      <= 1'b0;
         r_res_taken      <= 1'b0;
         r_redirect_valid <= 1'b0;
      end else if (flush) begin
         r_state          <= ST_IDLE;
         r_in_ready       <= 1'b1;
         r_res_valid      <= 1'b0;
         r_res_taken      <= 1'b0;
         r_redirect_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state          <= ST_RES;
                  r_cond           <= w_cond;
                  r_is_br          <= w_is_br;
                  r_target         <= w_target;
                  r_in_ready       <= 1'b0;
                  r_res_valid      <= 1'b1;
                  r_res_taken      <= w_cond;
                  r_redirect_valid <= w_cond;
               end
            end
            ST_RES: begin
               r_res_valid <= 1'b0;
               r_res_taken <= 1'b0;
               if (r_cond && !redirect_ack) begin
                  r_state <= ST_HOLD;
               end else begin
                  r_state          <= ST_IDLE;
                  r_in_ready       <= 1'b1;
                  r_redirect_valid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (redirect_ack) begin
                  r_state          <= ST_IDLE;
                  r_in_ready       <= 1'b1;
                  r_redirect_valid <= 1'b0;
               end
            end
            default: begin
               r_state          <= ST_IDLE;
               r_in_ready       <= 1'b1;
               r_res_valid      <= 1'b0;
               r_res_taken      <= 1'b0;
               r_redirect_valid <= 1'b0;
            end
         endcase
      end
   end

   // Kept apart from the FSM so a flush during RES still lets the stats update.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_br_count    <= '0;
         r_taken_count <= '0;
      end else if (w_cnt_inc) begin
         if (r_br_count != '1) r_br_count <= r_br_count + 1'b1;
         if (r_cond && (r_taken_count != '1)) r_taken_count <= r_taken_count + 1'b1;
      end
   end

   assign in_ready       = r_in_ready;
   assign res_valid      = r_res_valid;
   assign res_taken      = r_res_taken;
   assign redirect_valid = r_redirect_valid;
   assign redirect_addr  = r_target;
   assign br_count       = r_br_count;
   assign taken_count    = r_taken_count;

endmodule
